// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and state encodings for the seven-segment sequencer
package sseg_pkg;

  localparam logic [7:0] ADDR_DIG0   = 8'h01;
  localparam logic [7:0] ADDR_DECODE = 8'h09;
  localparam logic [7:0] ADDR_INTEN  = 8'h0A;
  localparam logic [7:0] ADDR_SCAN   = 8'h0B;
  localparam logic [7:0] ADDR_SHDN   = 8'h0C;
  localparam logic [7:0] ADDR_TEST   = 8'h0F;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_BLANK = 2'd2,
    ST_IDLE  = 2'd3
  } top_state_t;

  // HS_ISSUE doubles as the resting state: the handshake waits there for start.
  typedef enum logic [1:0] {
    HS_ISSUE     = 2'd0,
    HS_WAIT_DONE = 2'd1,
    HS_WAIT_REL  = 2'd2
  } hs_state_t;

  function automatic logic [15:0] mk_pkt(input logic [7:0] addr, input logic [7:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/sseg_ctl_pkt_hs.sv
// rtl/sseg_ctl_pkt_hs.sv - preq/pdone handshake for one packet with timeout detection
module pkt_hs
  import sseg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] pkt_in,
  input  logic        pdone,
  output logic        preq,
  output logic [15:0] pkt,
  output logic        done,
  output logic        tmo
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  hs_state_t       state;
  logic [TW-1:0]   tcnt;
  logic            sent;
  logic            at_limit;

  assign at_limit = (tcnt == TW'(TIMEOUT_CYC - 1));

  // A release that follows a real send completes a packet; a release that only
  // drained a stale pdone (after reset or timeout) does not.
  assign done = (state == HS_WAIT_REL) && !pdone && sent;

  assign tmo = at_limit && (((state == HS_WAIT_DONE) && !pdone) ||
                            ((state == HS_WAIT_REL)  &&  pdone));

  // Handshake sequencing; preq and pkt are registered and pkt only reloads on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HS_ISSUE;
      preq  <= 1'b0;
      pkt   <= 16'h0000;
      tcnt  <= '0;
      sent  <= 1'b0;
    end else begin
      case (state)
        HS_ISSUE: begin
          if (start) begin
            tcnt <= '0;
            if (pdone) begin
              sent  <= 1'b0;
              state <= HS_WAIT_REL;
            end else begin
              preq  <= 1'b1;
              pkt   <= pkt_in;
              sent  <= 1'b1;
              state <= HS_WAIT_DONE;
            end
          end
        end
        HS_WAIT_DONE: begin
          if (pdone) begin
            preq  <= 1'b0;
            tcnt  <= '0;
            state <= HS_WAIT_REL;
          end else if (at_limit) begin
            preq  <= 1'b0;
            tcnt  <= '0;
            sent  <= 1'b0;
            state <= HS_WAIT_REL;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HS_WAIT_REL: begin
          if (!pdone) begin
            state <= HS_ISSUE;
          end else if (at_limit) begin
            tcnt <= '0;
            sent <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= HS_ISSUE;
      endcase
    end
  end

endmodule

// File: rtl/sseg_ctl.sv
// rtl/sseg_ctl.sv - init, digit sweep and shutdown sequencer for a MAX7219-style driver
module sseg_ctl
  import sseg_pkg::*;
#(
  parameter int          REFRESH_CYC = 100000,
  parameter logic [3:0]  INTENSITY   = 4'h8,
  parameter logic [2:0]  SCAN_LIM    = 3'd7,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic        blank,
  input  logic        upd,
  input  logic        pdone,
  output logic        preq,
  output logic [15:0] pkt,
  output logic        busy,
  output logic        err
);

  localparam int RW = $clog2(REFRESH_CYC + 1);

  top_state_t    state;
  logic [2:0]    idx;
  logic [31:0]   snap;
  logic          blank_s;
  logic          pending;
  logic [RW-1:0] rcnt;
  logic          rcnt_sat;
  logic          start;
  logic          done;
  logic          tmo;
  logic [15:0]   pkt_sel;

  assign rcnt_sat = (rcnt == RW'(REFRESH_CYC - 1));
  assign start    = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Packet contents for the current state and index.
  always_comb begin
    pkt_sel = 16'h0000;
    case (state)
      ST_INIT: begin
        case (idx)
          3'd0:    pkt_sel = mk_pkt(ADDR_TEST,   8'h00);
          3'd1:    pkt_sel = mk_pkt(ADDR_SCAN,   {5'b0, SCAN_LIM});
          3'd2:    pkt_sel = mk_pkt(ADDR_DECODE, 8'hFF);
          3'd3:    pkt_sel = mk_pkt(ADDR_INTEN,  {4'h0, INTENSITY});
          default: pkt_sel = mk_pkt(ADDR_SHDN,   {7'b0, ~blank});
        endcase
      end
      ST_SWEEP: pkt_sel = mk_pkt(ADDR_DIG0 + {5'b0, idx}, {4'h0, snap[{idx, 2'b00} +: 4]});
      ST_BLANK: pkt_sel = mk_pkt(ADDR_SHDN, {7'b0, ~blank});
      default:  pkt_sel = 16'h0000;
    endcase
  end

  pkt_hs #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_hs (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pkt_in (pkt_sel),
    .pdone  (pdone),
    .preq   (preq),
    .pkt    (pkt),
    .done   (done),
    .tmo    (tmo)
  );

  // Top-level sequencing. pending is consumed when a sweep starts from IDLE so
  // that requests arriving mid-sweep survive to trigger exactly one more sweep.
  // blank_s is taken from the bit actually sent, which pkt still holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      idx     <= 3'd0;
      snap    <= 32'h0;
      blank_s <= 1'b0;
      pending <= 1'b0;
      rcnt    <= '0;
      err     <= 1'b0;
    end else begin
      if (!rcnt_sat) rcnt <= rcnt + 1'b1;
      if (upd && (state != ST_IDLE)) pending <= 1'b1;
      if (tmo) begin
        err   <= 1'b1;
        state <= ST_INIT;
        idx   <= 3'd0;
      end else begin
        case (state)
          ST_INIT: begin
            if (done) begin
              if (idx == 3'd4) begin
                blank_s <= ~pkt[0];
                snap    <= digits;
                idx     <= 3'd0;
                state   <= ST_SWEEP;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
          ST_SWEEP: begin
            if (done) begin
              if (idx == 3'd7) begin
                rcnt  <= '0;
                idx   <= 3'd0;
                state <= ST_IDLE;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
          ST_BLANK: begin
            if (done) begin
              blank_s <= ~pkt[0];
              state   <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (blank != blank_s) begin
              if (upd) pending <= 1'b1;
              state <= ST_BLANK;
            end else if (pending || upd || rcnt_sat) begin
              pending <= 1'b0;
              snap    <= digits;
              idx     <= 3'd0;
              state   <= ST_SWEEP;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sseg_ctl.sv
// tb/tb_sseg_ctl.sv - self-checking bench for sseg_ctl with a delayed-pdone sender model
module tb_sseg_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = 32'h1234_5678;
  logic        blank = 1'b0;
  logic        upd = 1'b0;
  logic        pdone = 1'b0;
  logic        preq;
  logic [15:0] pkt;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sseg_ctl #(
    .REFRESH_CYC(200),
    .INTENSITY  (4'h8),
    .SCAN_LIM   (3'd7),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .digits (digits),
    .blank  (blank),
    .upd    (upd),
    .pdone  (pdone),
    .preq   (preq),
    .pkt    (pkt),
    .busy   (busy),
    .err    (err)
  );

  // Sender model: pdone rises 20 cycles after preq, falls once preq is low.
  bit snd_en = 1'b1;
  bit hold_pd = 1'b0;
  int dly = 0;
  always @(posedge clk) begin
    if (hold_pd) begin
      pdone <= 1'b1;
      dly   <= 0;
    end else if (pdone) begin
      if (!preq) pdone <= 1'b0;
      dly <= 0;
    end else if (preq && snd_en) begin
      if (dly == 19) begin
        pdone <= 1'b1;
        dly   <= 0;
      end else begin
        dly <= dly + 1;
      end
    end else begin
      dly <= 0;
    end
  end

  // Packet log and protocol monitors.
  logic [15:0] log_q[$];
  logic        preq_q = 1'b0;
  logic [15:0] pkt_q = 16'h0;
  int bad_issue = 0;
  int unstable = 0;
  int run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    preq_q <= preq;
    pkt_q  <= pkt;
    if (preq && !preq_q) begin
      log_q.push_back(pkt);
      if (pdone) bad_issue <= bad_issue + 1;
    end
    if (preq && preq_q && (pkt != pkt_q)) unstable <= unstable + 1;
    if (preq) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input int max, output int n);
    n = 0;
    while (busy !== v && n < max) begin
      tick();
      n++;
    end
    if (busy !== v) begin
      checks++;
      failures++;
      $display("FAIL wait_busy timeout actual=%b required=%b", busy, v);
    end
  endtask

  task automatic wait_log(input int cnt, input int max);
    int n;
    n = 0;
    while (log_q.size() < cnt && n < max) begin
      tick();
      n++;
    end
    if (log_q.size() < cnt) begin
      checks++;
      failures++;
      $display("FAIL wait_log timeout actual=%0d required=%0d", log_q.size(), cnt);
    end
  endtask

  function automatic logic [15:0] log_at(input int k);
    if (log_q.size() > k) return log_q[k];
    return 16'hxxxx;
  endfunction

  typedef struct {
    logic [31:0]      digits;
    logic [7:0][15:0] exp;
  } sweep_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] init_exp [13];
    sweep_vec_t  vecs [3];
    int n;
    int hi;

    init_exp = '{16'h0F00, 16'h0B07, 16'h09FF, 16'h0A08, 16'h0C01,
                 16'h0108, 16'h0207, 16'h0306, 16'h0405, 16'h0504, 16'h0603, 16'h0702, 16'h0801};
    vecs[0].digits = 32'h8765_43F1;
    vecs[0].exp    = {16'h0808, 16'h0707, 16'h0606, 16'h0505, 16'h0404, 16'h0303, 16'h020F, 16'h0101};
    vecs[1].digits = 32'h0000_0000;
    vecs[1].exp    = {16'h0800, 16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100};
    vecs[2].digits = 32'h9FFF_1234;
    vecs[2].exp    = {16'h0809, 16'h070F, 16'h060F, 16'h050F, 16'h0401, 16'h0302, 16'h0203, 16'h0104};

    // Reset state and first-packet latency.
    tick();
    tick();
    chk("rst_preq", preq, 0);
    chk("rst_pkt", pkt, 16'h0000);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("first_preq", preq, 1);
    chk("first_pkt", pkt, 16'h0F00);

    // Init order followed by the first sweep.
    wait_log(13, 13 * 24 + 50);
    for (int k = 0; k < 13; k++) chk($sformatf("init_pkt%0d", k), log_at(k), init_exp[k]);
    wait_busy(1'b0, 100, n);
    chk("init_err", err, 0);

    // Automatic refresh 200 cycles after the sweep ends.
    wait_busy(1'b1, 300, n);
    chk("refresh_gap", n, 200);
    wait_busy(1'b0, 300, n);
    chk("refresh_pkt0", log_at(13), 16'h0108);

    // Sweep content, digits scrambled right after the snapshot.
    for (int i = 0; i < 3; i++) begin
      log_q.delete();
      digits = vecs[i].digits;
      upd = 1'b1;
      tick();
      upd = 1'b0;
      digits = ~vecs[i].digits;
      wait_busy(1'b0, 400, n);
      chk($sformatf("sweep%0d_count", i), log_q.size(), 8);
      for (int k = 0; k < 8; k++) chk($sformatf("sweep%0d_pkt%0d", i, k), log_at(k), vecs[i].exp[k]);
    end

    // Three upd pulses during a sweep collapse into one extra sweep.
    log_q.delete();
    upd = 1'b1;
    tick();
    upd = 1'b0;
    for (int j = 0; j < 3; j++) begin
      repeat (30) tick();
      upd = 1'b1;
      tick();
      upd = 1'b0;
    end
    wait_busy(1'b0, 300, n);
    wait_busy(1'b1, 10, n);
    chk("pending_gap", n, 1);
    wait_busy(1'b0, 300, n);
    chk("pending_pkts", log_q.size(), 16);

    // Blank toggles.
    log_q.delete();
    blank = 1'b1;
    wait_busy(1'b1, 5, n);
    wait_busy(1'b0, 100, n);
    repeat (3) tick();
    chk("blank_on_count", log_q.size(), 1);
    chk("blank_on_pkt", log_at(0), 16'h0C00);
    chk("blank_on_busy", busy, 0);
    log_q.delete();
    blank = 1'b0;
    wait_busy(1'b1, 5, n);
    wait_busy(1'b0, 100, n);
    repeat (3) tick();
    chk("blank_off_count", log_q.size(), 1);
    chk("blank_off_pkt", log_at(0), 16'h0C01);
    hi = 0;
    repeat (100) begin
      tick();
      if (busy) hi++;
    end
    chk("no_extra_sweep", hi, 0);

    // Timeout: sender never answers the next (refresh) packet.
    snd_en = 1'b0;
    n = 0;
    while (!err && n < 600) begin
      tick();
      n++;
    end
    chk("tmo_err", err, 1);
    chk("tmo_preq", preq, 0);
    chk("tmo_len", last_run, 64);
    snd_en = 1'b1;
    log_q.delete();
    wait_log(1, 20);
    chk("tmo_restart_pkt", log_at(0), 16'h0F00);
    chk("tmo_err_sticky", err, 1);

    // Reset while packet 3 is in flight, sender holds pdone past release.
    wait_log(3, 200);
    chk("rstmid_pkt3", log_at(2), 16'h09FF);
    rst = 1'b1;
    hold_pd = 1'b1;
    tick();
    chk("rstmid_preq_drop", preq, 0);
    tick();
    rst = 1'b0;
    hi = 0;
    repeat (10) begin
      tick();
      if (preq) hi++;
    end
    chk("rstmid_preq_held", hi, 0);
    chk("rstmid_err", err, 0);
    log_q.delete();
    hold_pd = 1'b0;
    wait_log(1, 20);
    chk("rstmid_restart_pkt", log_at(0), 16'h0F00);

    chk("issue_while_pdone", bad_issue, 0);
    chk("pkt_stable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
